pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Consumes decoded register fields and write controls from the ID, EX, MEM and WB pipeline registers, the EX-stage redirect, and the data-memory ready handshake.
- Produces per-register stall/flush strobes and EX operand forwarding selects.
- Owns the data-memory wait FSM and hazard performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 56 +++++
 tb/tb_pipe_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline register fields in, stall/flush/forward controls and hazard counters out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rf_ra1, id_rf_ra2, ex_rf_ra1, ex_rf_ra2, ex_rf_wa, mem_rf_wa, wb_rf_wa;
  logic ex_rf_we, mem_rf_we, wb_rf_we, ex_br_taken, mem_req, dmem_ready;
  logic [1:0] ex_rf_wd_sel, fwd_sel1, fwd_sel2;
  logic if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, wb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master(
    output id_rf_ra1, id_rf_ra2, ex_rf_ra1, ex_rf_ra2, ex_rf_wa, ex_rf_we, ex_rf_wd_sel, ex_br_taken,
           mem_rf_wa, mem_rf_we, mem_req, dmem_ready, wb_rf_wa, wb_rf_we,
    input if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, wb_flush, fwd_sel1, fwd_sel2,
          stall_cnt, flush_cnt
  );
  modport slave(
    input id_rf_ra1, id_rf_ra2, ex_rf_ra1, ex_rf_ra2, ex_rf_wa, ex_rf_we, ex_rf_wd_sel, ex_br_taken,
          mem_rf_wa, mem_rf_we, mem_req, dmem_ready, wb_rf_wa, wb_rf_we,
    output if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, wb_flush, fwd_sel1, fwd_sel2,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush/forwarding control, dmem wait FSM, hazard counters.
// Optional macro FWD_EN enables EX operand forwarding (otherwise stall on any RAW against EX/MEM).
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave h
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0] state;
  logic mem_busy, hz, br;
  logic [1:0] fwd1, fwd2;
  assign mem_busy = ~h.dmem_ready & (state == WAIT | h.mem_req);
`ifdef FWD_EN
  assign hz = h.ex_rf_we & h.ex_rf_wd_sel == 2'b10 & h.ex_rf_wa != 5'd0 &
              (h.ex_rf_wa == h.id_rf_ra1 | h.ex_rf_wa == h.id_rf_ra2);
  always_comb begin
    fwd1 = (h.mem_rf_we & h.mem_rf_wa != 5'd0 & h.mem_rf_wa == h.ex_rf_ra1) ? 2'b01 :
           (h.wb_rf_we & h.wb_rf_wa != 5'd0 & h.wb_rf_wa == h.ex_rf_ra1) ? 2'b10 : 2'b00;
    fwd2 = (h.mem_rf_we & h.mem_rf_wa != 5'd0 & h.mem_rf_wa == h.ex_rf_ra2) ? 2'b01 :
           (h.wb_rf_we & h.wb_rf_wa != 5'd0 & h.wb_rf_wa == h.ex_rf_ra2) ? 2'b10 : 2'b00;
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{h.ex_rf_ra1, h.ex_rf_ra2, h.wb_rf_wa, h.wb_rf_we, h.ex_rf_wd_sel};
  assign hz = (h.ex_rf_we & h.ex_rf_wa != 5'd0 & (h.ex_rf_wa == h.id_rf_ra1 | h.ex_rf_wa == h.id_rf_ra2)) |
              (h.mem_rf_we & h.mem_rf_wa != 5'd0 & (h.mem_rf_wa == h.id_rf_ra1 | h.mem_rf_wa == h.id_rf_ra2));
  assign fwd1 = 2'b00;
  assign fwd2 = 2'b00;
`endif
  assign br = ~mem_busy & h.ex_br_taken;
  always_comb begin
    h.if_stall = ~rst & (mem_busy | (~h.ex_br_taken & hz));
    h.id_stall = h.if_stall;
    h.ex_stall = ~rst & mem_busy;
    h.mem_stall = h.ex_stall;
    h.id_flush = rst | br;
    h.ex_flush = rst | (~mem_busy & (h.ex_br_taken | hz));
    h.wb_flush = rst | mem_busy;
    h.fwd_sel1 = rst ? 2'b00 : fwd1;
    h.fwd_sel2 = rst ? 2'b00 : fwd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h.stall_cnt <= '0;
      h.flush_cnt <= '0;
    end else begin
      state <= (state == IDLE) ? ((h.mem_req & ~h.dmem_ready) ? WAIT : IDLE) : (h.dmem_ready ? IDLE : WAIT);
      if (h.if_stall & ~&h.stall_cnt) h.stall_cnt <= h.stall_cnt + CNT_W'(1);
      if (br & ~&h.flush_cnt) h.flush_cnt <= h.flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized stimulus checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  bit pending = 0;
  int unsigned m_stall = 0, m_flush = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(32)) h();
  pipe_hazard_ctrl #(.CNT_W(32)) dut(.clk(clk), .rst(rst), .h(h));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input logic we, input logic [4:0] wa, input logic [4:0] r);
    return we && wa != 0 && wa == r;
  endfunction

  function automatic logic [1:0] src(input logic [4:0] r);
    if (writes(h.mem_rf_we, h.mem_rf_wa, r)) return 2'b01;
    if (writes(h.wb_rf_we, h.wb_rf_wa, r)) return 2'b10;
    return 2'b00;
  endfunction

  // One cycle: inputs already driven after negedge; check combinational outputs, then advance model on posedge.
  task automatic cycle();
    bit busy, brk, hz;
    logic [3:0] es;
    logic [2:0] ef;
    #1;
    busy = !h.dmem_ready && (pending || h.mem_req);
`ifdef FWD_EN
    hz = h.ex_rf_wd_sel == 2'b10 && (writes(h.ex_rf_we, h.ex_rf_wa, h.id_rf_ra1) || writes(h.ex_rf_we, h.ex_rf_wa, h.id_rf_ra2));
`else
    hz = writes(h.ex_rf_we, h.ex_rf_wa, h.id_rf_ra1) || writes(h.ex_rf_we, h.ex_rf_wa, h.id_rf_ra2) ||
         writes(h.mem_rf_we, h.mem_rf_wa, h.id_rf_ra1) || writes(h.mem_rf_we, h.mem_rf_wa, h.id_rf_ra2);
`endif
    brk = !busy && h.ex_br_taken;
    if (rst) begin es = 4'b0000; ef = 3'b111; end
    else if (busy) begin es = 4'b1111; ef = 3'b001; end
    else if (h.ex_br_taken) begin es = 4'b0000; ef = 3'b110; end
    else if (hz) begin es = 4'b1100; ef = 3'b010; end
    else begin es = 4'b0000; ef = 3'b000; end
    check("stalls", {h.if_stall, h.id_stall, h.ex_stall, h.mem_stall}, es);
    check("flushes", {h.id_flush, h.ex_flush, h.wb_flush}, ef);
`ifdef FWD_EN
    check("fwd_sel1", h.fwd_sel1, rst ? 2'b00 : src(h.ex_rf_ra1));
    check("fwd_sel2", h.fwd_sel2, rst ? 2'b00 : src(h.ex_rf_ra2));
`else
    check("fwd_sel1", h.fwd_sel1, 2'b00);
    check("fwd_sel2", h.fwd_sel2, 2'b00);
`endif
    @(posedge clk);
    if (rst) begin
      pending = 0; m_stall = 0; m_flush = 0;
    end else begin
      pending = pending ? !h.dmem_ready : (h.mem_req && !h.dmem_ready);
      if (es[3] && m_stall != 32'hffff_ffff) m_stall++;
      if (brk && m_flush != 32'hffff_ffff) m_flush++;
    end
    #1;
    check("stall_cnt", h.stall_cnt, m_stall);
    check("flush_cnt", h.flush_cnt, m_flush);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {h.id_rf_ra1, h.id_rf_ra2, h.ex_rf_ra1, h.ex_rf_ra2, h.ex_rf_wa, h.mem_rf_wa, h.wb_rf_wa} = '0;
    {h.ex_rf_we, h.mem_rf_we, h.wb_rf_we, h.ex_br_taken, h.mem_req, h.dmem_ready} = '0;
    h.ex_rf_wd_sel = 2'b00;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    cycle();
    // load-use on x5 followed by the forwarded consumer
    h.ex_rf_we = 1; h.ex_rf_wa = 5; h.ex_rf_wd_sel = 2'b10; h.id_rf_ra1 = 5;
    cycle();
    idle_inputs(); h.wb_rf_we = 1; h.wb_rf_wa = 5; h.ex_rf_ra1 = 5;
    cycle();
    // EX-MEM beats MEM-WB, and x0 never forwards
    idle_inputs(); h.mem_rf_we = 1; h.mem_rf_wa = 3; h.wb_rf_we = 1; h.wb_rf_wa = 3; h.ex_rf_ra2 = 3;
    cycle();
    h.mem_rf_wa = 0; h.wb_rf_wa = 0; h.ex_rf_ra2 = 0;
    cycle();
    // 3-cycle memory wait with a branch held behind it
    idle_inputs(); h.mem_req = 1; h.ex_br_taken = 1;
    repeat (3) cycle();
    h.dmem_ready = 1;
    cycle();
    idle_inputs(); h.ex_br_taken = 1;
    cycle();
    // ALU RAW on x7 (two stall cycles without forwarding), then reset mid-wait
    idle_inputs(); h.ex_rf_we = 1; h.ex_rf_wa = 7; h.id_rf_ra2 = 7;
    cycle();
    idle_inputs(); h.mem_rf_we = 1; h.mem_rf_wa = 7; h.id_rf_ra2 = 7;
    cycle();
    idle_inputs(); h.mem_req = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0; h.mem_req = 0; h.dmem_ready = 1;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      h.id_rf_ra1 = 5'($urandom_range(0, 3));
      h.id_rf_ra2 = 5'($urandom_range(0, 3));
      h.ex_rf_ra1 = 5'($urandom_range(0, 3));
      h.ex_rf_ra2 = 5'($urandom_range(0, 3));
      h.ex_rf_wa = 5'($urandom_range(0, 3));
      h.mem_rf_wa = 5'($urandom_range(0, 3));
      h.wb_rf_wa = 5'($urandom_range(0, 3));
      h.ex_rf_we = 1'($urandom);
      h.mem_rf_we = 1'($urandom);
      h.wb_rf_we = 1'($urandom);
      h.ex_rf_wd_sel = 2'($urandom);
      h.ex_br_taken = ($urandom_range(0, 3) == 0);
      h.mem_req = 1'($urandom);
      h.dmem_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
